// File: rtl/apb_master_arbiter.sv
// Two-requester round-robin APB master with a 16-way PSEL decode.
// Optional ACCESS-phase wait timeout is compiled in by defining APB_TIMEOUT_EN.
module apb_master_arbiter #(
  parameter int SLOT_LSB = 24,
  parameter int TIMEOUT  = 255
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic        REQ0,
  input  logic        WR0,
  input  logic [31:0] ADDR0,
  input  logic [31:0] WDATA0,
  output logic        ACK0,
  output logic [31:0] RDATA0,
  output logic        ERR0,
  input  logic        REQ1,
  input  logic        WR1,
  input  logic [31:0] ADDR1,
  input  logic [31:0] WDATA1,
  output logic        ACK1,
  output logic [31:0] RDATA1,
  output logic        ERR1,
  output logic [31:0] PADDR,
  output logic [15:0] PSEL,
  output logic        PENABLE,
  output logic        PWRITE,
  output logic [31:0] PWDATA,
  input  logic [31:0] PRDATA,
  input  logic        PREADY,
  input  logic        PSLVERR,
  output logic        BUSY
);
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETUP  = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;

  logic [1:0]       state;
  logic             rr_ptr;   // requester that wins a tie
  logic             owner;    // requester of the transfer in flight
  logic [1:0]       ack, err, elig;
  logic [1:0][31:0] rdata;
  logic             grant_vld, grant_sel, timeout_hit;
  logic [3:0]       slot;

  // A requester being acked this cycle still holds REQ; mask it so it cannot re-win
  assign elig      = {REQ1 & ~ack[1], REQ0 & ~ack[0]};
  assign grant_vld = |elig;
  assign grant_sel = (&elig) ? rr_ptr : elig[1];
  assign slot      = grant_sel ? ADDR1[SLOT_LSB +: 4] : ADDR0[SLOT_LSB +: 4];

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state   <= IDLE;
      rr_ptr  <= 1'b0;
      owner   <= 1'b0;
      PADDR   <= '0;
      PWRITE  <= 1'b0;
      PWDATA  <= '0;
      PSEL    <= '0;
      PENABLE <= 1'b0;
      ack     <= '0;
      err     <= '0;
      rdata   <= '0;
    end else begin
      ack <= '0;
      err <= '0;
      case (state)
        IDLE: if (grant_vld) begin
          state  <= SETUP;
          owner  <= grant_sel;
          rr_ptr <= ~grant_sel;
          PADDR  <= grant_sel ? ADDR1  : ADDR0;
          PWRITE <= grant_sel ? WR1    : WR0;
          PWDATA <= grant_sel ? WDATA1 : WDATA0;
          PSEL   <= 16'd1 << slot;
        end
        SETUP: begin
          state   <= ACCESS;
          PENABLE <= 1'b1;
        end
        ACCESS: if (PREADY || timeout_hit) begin
          state      <= IDLE;
          PSEL       <= '0;
          PENABLE    <= 1'b0;
          ack[owner] <= 1'b1;
          err[owner] <= PREADY ? PSLVERR : 1'b1;
          // a timed-out read leaves the previous read data in place
          if (PREADY && !PWRITE) rdata[owner] <= PRDATA;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef APB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] wait_cnt;

  assign timeout_hit = (state == ACCESS) && !PREADY && (wait_cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge PCLK) begin
    if (PRESET || state != ACCESS || PREADY || timeout_hit) wait_cnt <= '0;
    else                                                    wait_cnt <= wait_cnt + CW'(1);
  end
`else
  logic unused_timeout;
  assign timeout_hit    = 1'b0;
  assign unused_timeout = (TIMEOUT > 0);
`endif

  assign BUSY   = (state != IDLE);
  assign ACK0   = ack[0];
  assign ACK1   = ack[1];
  assign ERR0   = err[0];
  assign ERR1   = err[1];
  assign RDATA0 = rdata[0];
  assign RDATA1 = rdata[1];
endmodule
